// File: rtl/hex_display_ctrl_if.sv
// Host-side bus of the hex display controller: load strobe, value, and live
// per-digit blink/decimal-point requests.
interface hex_display_ctrl_if #(
  parameter int NUM_DIGITS = 6
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic                    blank_lz;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic [NUM_DIGITS-1:0]   dp_in;

  modport master (output load, value, blank_lz, blink_mask, dp_in);
  modport slave  (input  load, value, blank_lz, blink_mask, dp_in);
endinterface

// File: rtl/hex_display_ctrl.sv
// Registered N-digit hex to 7-segment driver with leading-zero blanking, per-digit
// blink and decimal points, producing parallel per-digit buses and a multiplexed scan port.
module hex_display_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int BLINK_DIV  = 25_000_000,
  parameter int SCAN_DIV   = 50_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  hex_display_ctrl_if.slave       bus,
  output logic [7*NUM_DIGITS-1:0] hex_segs,
  output logic [NUM_DIGITS-1:0]   hex_dp,
  output logic [7:0]              scan_segs,
  output logic [NUM_DIGITS-1:0]   scan_sel,
  output logic                    blink_phase,
  output logic                    updated
);

  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  // Pin levels: the decode table is written active-low and flipped when ACTIVE_LOW=0.
  localparam logic [6:0] SEG_INV   = ACTIVE_LOW ? 7'h00 : 7'h7F;
  localparam logic [6:0] SEG_BLANK = 7'h7F ^ SEG_INV;
  localparam logic       DP_DARK   = ACTIVE_LOW;
  localparam logic       SEL_OFF   = ACTIVE_LOW;

  function automatic logic [6:0] decode_low(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic                    lz_q, lz_d;
  logic                    have_value_q, have_value_d;
  logic                    load_q, load_d;
  logic                    updated_q, updated_d;
  logic [BLINK_W-1:0]      blink_cnt_q, blink_cnt_d;
  logic                    blink_phase_q, blink_phase_d;
  logic [SCAN_W-1:0]       scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]        scan_idx_q, scan_idx_d;
  logic [7*NUM_DIGITS-1:0] hex_segs_q, hex_segs_d;
  logic [NUM_DIGITS-1:0]   hex_dp_q, hex_dp_d;
  logic [7:0]              scan_segs_q, scan_segs_d;
  logic [NUM_DIGITS-1:0]   scan_sel_q, scan_sel_d;

  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    leading;

  // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    value_d      = value_q;
    lz_d         = lz_q;
    have_value_d = have_value_q;
    load_d       = bus.load;
    updated_d    = load_q;
    if (bus.load) begin
      value_d      = bus.value;
      lz_d         = bus.blank_lz;
      have_value_d = 1'b1;
    end
  end

  always_comb begin
    blink_cnt_d   = blink_cnt_q + 1'b1;
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end

    scan_cnt_d = scan_cnt_q + 1'b1;
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + 1'b1;
    end
  end

  // NOTE: 'leading' is a blocking scratch variable carried down the digit loop, not state.
  always_comb begin
    leading  = lz_q;
    lz_blank = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (value_q[4*i +: 4] != 4'h0) leading = 1'b0;
      lz_blank[i] = leading;
    end
  end

  always_comb begin
    hex_segs_d = {NUM_DIGITS{SEG_BLANK}};
    hex_dp_d   = {NUM_DIGITS{DP_DARK}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (have_value_q && !(blink_phase_q && bus.blink_mask[i])) begin
        hex_segs_d[7*i +: 7] = lz_blank[i] ? SEG_BLANK
                                           : (decode_low(value_q[4*i +: 4]) ^ SEG_INV);
        hex_dp_d[i]          = bus.dp_in[i] ? ~DP_DARK : DP_DARK;
      end
    end
  end

  // The scan port samples the already-registered digit buses, hence one cycle behind them.
  always_comb begin
    scan_sel_d             = {NUM_DIGITS{SEL_OFF}};
    scan_sel_d[scan_idx_q] = ~SEL_OFF;
    scan_segs_d            = {hex_dp_q[scan_idx_q], hex_segs_q[7*scan_idx_q +: 7]};
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q       <= '0;
      lz_q          <= 1'b0;
      have_value_q  <= 1'b0;
      load_q        <= 1'b0;
      updated_q     <= 1'b0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      scan_cnt_q    <= '0;
      scan_idx_q    <= '0;
      hex_segs_q    <= {NUM_DIGITS{SEG_BLANK}};
      hex_dp_q      <= {NUM_DIGITS{DP_DARK}};
      scan_segs_q   <= {DP_DARK, SEG_BLANK};
      scan_sel_q    <= {NUM_DIGITS{SEL_OFF}};
    end else begin
      value_q       <= value_d;
      lz_q          <= lz_d;
      have_value_q  <= have_value_d;
      load_q        <= load_d;
      updated_q     <= updated_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      scan_cnt_q    <= scan_cnt_d;
      scan_idx_q    <= scan_idx_d;
      hex_segs_q    <= hex_segs_d;
      hex_dp_q      <= hex_dp_d;
      scan_segs_q   <= scan_segs_d;
      scan_sel_q    <= scan_sel_d;
    end
  end

  assign hex_segs    = hex_segs_q;
  assign hex_dp      = hex_dp_q;
  assign scan_segs   = scan_segs_q;
  assign scan_sel    = scan_sel_q;
  assign blink_phase = blink_phase_q;
  assign updated     = updated_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Randomized bench for hex_display_ctrl: two configurations (active-low 6 digits,
// active-high 4 digits with single-cycle scan) checked against a cycle-level reference model.
module tb_hex_display_ctrl;

  localparam int ND0 = 6, BD0 = 4, SD0 = 2;
  localparam int ND1 = 4, BD1 = 2, SD1 = 1;

  localparam logic [6:0] SEG_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hex_display_ctrl_if #(.NUM_DIGITS(ND0)) bus0 ();
  hex_display_ctrl_if #(.NUM_DIGITS(ND1)) bus1 ();

  logic [7*ND0-1:0] segs0;
  logic [ND0-1:0]   dp0, ssel0;
  logic [7:0]       ssegs0;
  logic             phase0, upd0;
  logic [7*ND1-1:0] segs1;
  logic [ND1-1:0]   dp1, ssel1;
  logic [7:0]       ssegs1;
  logic             phase1, upd1;

  hex_display_ctrl #(.NUM_DIGITS(ND0), .ACTIVE_LOW(1'b1), .BLINK_DIV(BD0), .SCAN_DIV(SD0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave),
    .hex_segs(segs0), .hex_dp(dp0), .scan_segs(ssegs0), .scan_sel(ssel0),
    .blink_phase(phase0), .updated(upd0));

  hex_display_ctrl #(.NUM_DIGITS(ND1), .ACTIVE_LOW(1'b0), .BLINK_DIV(BD1), .SCAN_DIV(SD1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave),
    .hex_segs(segs1), .hex_dp(dp1), .scan_segs(ssegs1), .scan_sel(ssel1),
    .blink_phase(phase1), .updated(upd1));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: state per instance, expected outputs after the latest edge.
  int   cfg_nd [2] = '{ND0, ND1};
  int   cfg_bd [2] = '{BD0, BD1};
  int   cfg_sd [2] = '{SD0, SD1};
  bit   cfg_al [2] = '{1'b1, 1'b0};

  int          n_m    [2];
  logic [31:0] val_m  [2];
  bit          lz_m   [2];
  bit          have_m [2];
  bit          loadp_m[2];

  logic [55:0] e_segs [2];
  logic [7:0]  e_dp   [2];
  logic [7:0]  e_ssegs[2];
  logic [7:0]  e_ssel [2];
  bit          e_upd  [2];
  bit          e_phase[2];

  function automatic logic [6:0] blank7(input bit al);
    return al ? 7'h7F : 7'h00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      n_m[i] = 0; val_m[i] = '0; lz_m[i] = 1'b0; have_m[i] = 1'b0; loadp_m[i] = 1'b0;
      e_segs[i] = '0; e_dp[i] = '0; e_ssel[i] = '0;
      for (int k = 0; k < cfg_nd[i]; k++) begin
        e_segs[i][7*k +: 7] = blank7(cfg_al[i]);
        e_dp[i][k]          = cfg_al[i];
        e_ssel[i][k]        = cfg_al[i];
      end
      e_ssegs[i] = {cfg_al[i], blank7(cfg_al[i])};
      e_upd[i]   = 1'b0;
      e_phase[i] = 1'b0;
    end
  endtask

  task automatic model_step(input int i, input bit ld, input logic [31:0] v, input bit blz,
                            input logic [7:0] bm, input logic [7:0] dpi);
    int nd, ph, idx, msd;
    bit al;
    logic [3:0]  nib;
    logic [55:0] segs;
    logic [7:0]  dps, sel;
    nd  = cfg_nd[i];
    al  = cfg_al[i];
    ph  = (n_m[i] / cfg_bd[i]) % 2;
    idx = (n_m[i] / cfg_sd[i]) % nd;
    msd = 0;
    segs = '0; dps = '0; sel = '0;
    for (int k = 0; k < nd; k++) begin
      sel[k] = (k == idx) ? ~al : al;
      if (val_m[i][4*k +: 4] != 4'h0) msd = k;
    end
    for (int k = 0; k < nd; k++) begin
      segs[7*k +: 7] = blank7(al);
      dps[k]         = al;
      if (have_m[i] && !(ph == 1 && bm[k])) begin
        nib            = val_m[i][4*k +: 4];
        segs[7*k +: 7] = (lz_m[i] && k > msd) ? blank7(al) : (al ? SEG_TAB[nib] : ~SEG_TAB[nib]);
        dps[k]         = dpi[k] ? ~al : al;
      end
    end
    e_ssegs[i] = {e_dp[i][idx], e_segs[i][7*idx +: 7]};
    e_ssel[i]  = sel;
    e_segs[i]  = segs;
    e_dp[i]    = dps;
    e_upd[i]   = loadp_m[i];
    loadp_m[i] = ld;
    if (ld) begin
      val_m[i]  = v;
      lz_m[i]   = blz;
      have_m[i] = 1'b1;
    end
    n_m[i]++;
    e_phase[i] = ((n_m[i] / cfg_bd[i]) % 2) == 1;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".segs0"},  64'(segs0),  64'(e_segs[0]));
    check({tag, ".dp0"},    64'(dp0),    64'(e_dp[0]));
    check({tag, ".ssegs0"}, 64'(ssegs0), 64'(e_ssegs[0]));
    check({tag, ".ssel0"},  64'(ssel0),  64'(e_ssel[0]));
    check({tag, ".upd0"},   64'(upd0),   64'(e_upd[0]));
    check({tag, ".phase0"}, 64'(phase0), 64'(e_phase[0]));
    check({tag, ".segs1"},  64'(segs1),  64'(e_segs[1]));
    check({tag, ".dp1"},    64'(dp1),    64'(e_dp[1]));
    check({tag, ".ssegs1"}, 64'(ssegs1), 64'(e_ssegs[1]));
    check({tag, ".ssel1"},  64'(ssel1),  64'(e_ssel[1]));
    check({tag, ".upd1"},   64'(upd1),   64'(e_upd[1]));
    check({tag, ".phase1"}, 64'(phase1), 64'(e_phase[1]));
  endtask

  // Inputs are already driven; advance one edge, update the model, compare on the falling edge.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_step(0, bus0.load, 32'(bus0.value), bus0.blank_lz, 8'(bus0.blink_mask), 8'(bus0.dp_in));
    model_step(1, bus1.load, 32'(bus1.value), bus1.blank_lz, 8'(bus1.blink_mask), 8'(bus1.dp_in));
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic idle_inputs();
    bus0.load = 1'b0; bus0.value = '0; bus0.blank_lz = 1'b0; bus0.blink_mask = '0; bus0.dp_in = '0;
    bus1.load = 1'b0; bus1.value = '0; bus1.blank_lz = 1'b0; bus1.blink_mask = '0; bus1.dp_in = '0;
  endtask

  function automatic logic [31:0] rand_value(input int nd);
    logic [31:0] v;
    v = $urandom();
    if ($urandom_range(0, 7) == 0) v = '0;
    else v = v >> (32 - 4 * $urandom_range(1, nd));
    return v;
  endfunction

  task automatic drive_random();
    logic [31:0] v;
    bus0.load       = ($urandom_range(0, 3) == 0);
    v               = rand_value(ND0);
    bus0.value      = v[4*ND0-1:0];
    bus0.blank_lz   = 1'($urandom_range(0, 1));
    bus0.blink_mask = ($urandom_range(0, 1) == 0) ? '0 : ND0'($urandom());
    bus0.dp_in      = ND0'($urandom());
    bus1.load       = ($urandom_range(0, 2) == 0);
    v               = rand_value(ND1);
    bus1.value      = v[4*ND1-1:0];
    bus1.blank_lz   = 1'($urandom_range(0, 1));
    bus1.blink_mask = ND1'($urandom());
    bus1.dp_in      = ND1'($urandom());
  endtask

  int dark_cnt, d1_bad, sel0_cnt;

  initial begin
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    compare_all("reset");
    rst_n = 1'b1;

    // Idle after reset: blank everywhere, no update pulse.
    for (int c = 0; c < 10; c++) cycle("idle");
    check("idle.all_blank", 64'(segs0), 64'({ND0{7'h7F}}));

    // Plain load of 0x00A3F0.
    bus0.load = 1'b1; bus0.value = 24'h00A3F0; bus0.blank_lz = 1'b0;
    cycle("t2.cap");
    check("t2.upd_at_capture", 64'(upd0), 64'(0));
    bus0.load = 1'b0;
    cycle("t2.show");
    check("t2.segs", 64'(segs0), 64'({7'h40, 7'h40, 7'h08, 7'h30, 7'h0E, 7'h40}));
    check("t2.upd", 64'(upd0), 64'(1));
    cycle("t2.after");
    check("t2.upd_drop", 64'(upd0), 64'(0));

    // Leading-zero blanking.
    bus0.load = 1'b1; bus0.value = 24'h00A3F0; bus0.blank_lz = 1'b1;
    cycle("t3a.cap");
    bus0.load = 1'b0;
    cycle("t3a.show");
    check("t3a.segs", 64'(segs0), 64'({7'h7F, 7'h7F, 7'h08, 7'h30, 7'h0E, 7'h40}));
    bus0.load = 1'b1; bus0.value = 24'h000000; bus0.blank_lz = 1'b1;
    cycle("t3b.cap");
    bus0.load = 1'b0;
    cycle("t3b.show");
    check("t3b.segs", 64'(segs0), 64'({{5{7'h7F}}, 7'h40}));

    // Blink digit 0 only, value 0, no blanking: period of 8 edges, dark half the time.
    bus0.load = 1'b1; bus0.value = '0; bus0.blank_lz = 1'b0; bus0.blink_mask = 6'b000001;
    cycle("t4.cap");
    bus0.load = 1'b0;
    cycle("t4.settle");
    dark_cnt = 0; d1_bad = 0;
    for (int c = 0; c < 8; c++) begin
      cycle("t4");
      if (segs0[6:0] == 7'h7F) dark_cnt++;
      if (segs0[13:7] != 7'h40) d1_bad++;
    end
    check("t4.d0_dark_cycles", 64'(dark_cnt), 64'(4));
    check("t4.d1_unsteady", 64'(d1_bad), 64'(0));

    // Scan: each digit selected for SD0 cycles in every ND0*SD0 window.
    sel0_cnt = 0;
    for (int c = 0; c < ND0 * SD0; c++) begin
      cycle("t5");
      if (ssel0 == 6'b111110) sel0_cnt++;
    end
    check("t5.digit0_slots", 64'(sel0_cnt), 64'(SD0));

    // Randomized traffic with one asynchronous reset in the middle.
    for (int c = 0; c < 400; c++) begin
      drive_random();
      if (c == 200) begin
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        bus0.load = 1'b1;
        bus1.load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        compare_all("rst_hold");
        rst_n = 1'b1;
        idle_inputs();
        for (int k = 0; k < 6; k++) cycle("post_rst");
        check("post_rst.blank", 64'(segs0), 64'({ND0{7'h7F}}));
        drive_random();
      end
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
